placar_parametrizado: RTL and testbench

//  Parametrised scoreboard. Scans an N-bit enemy-alive vector one bit per cycle and detects kills
//  (alive 1 -> dead 0). Accumulates the current score in packed BCD and keeps a high score
//  (recorde) across games. Runs a PLAYING / GAME_OVER state machine driven by the game-over and

---
 rtl/placar_parametrizado.sv | 145 ++++++++++++++
 tb/tb_placar_parametrizado.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/placar_parametrizado.sv
`default_nettype none
// ============================================================================
// Module   : placar_parametrizado
// Purpose  : Kill-scanning packed-BCD scoreboard with a persistent high score
//            and a PLAYING / GAME_OVER state machine.
// Revision : 1.0 - initial release
// ============================================================================
module placar_parametrizado #(
    parameter int N_INIMIGOS       = 64,
    parameter int N_DIGITOS        = 3,
    parameter int PONTOS_POR_ABATE = 1,
    parameter bit SATURAR          = 1'b0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [N_INIMIGOS-1:0]  inimigosvida,
    input  logic                   perdeuJogo,
    input  logic                   reiniciarJogo,
    output logic [4*N_DIGITOS-1:0] placar_bcd,
    output logic [4*N_DIGITOS-1:0] recorde_bcd,
    output logic                   ponto,
    output logic                   estouro,
    output logic                   novo_recorde,
    output logic                   jogando
);

    localparam int                 c_IDX_W    = $clog2(N_INIMIGOS);
    localparam int                 c_W        = 4 * N_DIGITOS;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_INIMIGOS - 1);
    localparam logic [3:0]         c_PONTOS   = 4'(PONTOS_POR_ABATE);
    localparam logic [c_W-1:0]     c_MAX      = {N_DIGITOS{4'h9}};

    typedef enum logic [0:0] {
        S_PLAYING   = 1'b0,
        S_GAME_OVER = 1'b1
    } estado_t;

    estado_t                 r_estado;
    estado_t                 w_estado_prox;
    logic [c_IDX_W-1:0]      r_idx;
    logic [N_INIMIGOS-1:0]   r_snap;
    logic [c_W-1:0]          r_placar;
    logic [c_W-1:0]          r_recorde;
    logic                    r_ponto;
    logic                    r_estouro;
    logic                    r_novo_recorde;

    logic [c_W-1:0]          w_soma;
    logic [c_W-1:0]          w_placar_prox;
    logic [4:0]              w_dig;
    logic                    w_carry;
    logic                    w_abate;
    logic                    w_pontua;
    logic                    w_muda;
    logic                    w_estouro;

    // ---------------- state machine ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_estado <= S_PLAYING;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        if (reiniciarJogo) begin
            w_estado_prox = S_PLAYING;
        end else if ((r_estado == S_PLAYING) && perdeuJogo) begin
            w_estado_prox = S_GAME_OVER;
        end
    end

    // ---------------- ripple BCD adder ----------------
    // Digit 0 receives the per-kill points, upper digits only the decimal carry;
    // the carry out of the top digit marks the overflow past all-nines.
    always_comb begin
        w_carry = 1'b0;
        w_dig   = '0;
        w_soma  = r_placar;
        for (int d = 0; d < N_DIGITOS; d++) begin
            w_dig = {1'b0, r_placar[4*d +: 4]} + ((d == 0) ? {1'b0, c_PONTOS} : {4'b0000, w_carry});
            if (w_dig > 5'd9) begin
                w_soma[4*d +: 4] = 4'(w_dig - 5'd10);
                w_carry          = 1'b1;
            end else begin
                w_soma[4*d +: 4] = w_dig[3:0];
                w_carry          = 1'b0;
            end
        end
    end

    always_comb begin
        w_placar_prox = (SATURAR && w_carry) ? c_MAX : w_soma;
        w_muda        = (w_placar_prox != r_placar);
        w_estouro     = SATURAR ? ((w_placar_prox == c_MAX) && (r_placar != c_MAX)) : w_carry;
        w_abate       = r_snap[r_idx] & ~inimigosvida[r_idx];
        w_pontua      = w_abate && (r_estado == S_PLAYING) && !perdeuJogo && !reiniciarJogo;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_idx          <= '0;
            r_snap         <= inimigosvida;
            r_placar       <= '0;
            r_recorde      <= '0;
            r_ponto        <= 1'b0;
            r_estouro      <= 1'b0;
            r_novo_recorde <= 1'b0;
        end else begin
            r_ponto   <= 1'b0;
            r_estouro <= 1'b0;
            // Packed BCD orders like unsigned binary, so a plain compare is a magnitude compare.
            if (r_placar > r_recorde) begin
                r_recorde      <= r_placar;
                r_novo_recorde <= 1'b1;
            end
            if (reiniciarJogo) begin
                r_idx          <= '0;
                r_snap         <= inimigosvida;
                r_placar       <= '0;
                r_novo_recorde <= 1'b0;
            end else begin
                r_idx         <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
                r_snap[r_idx] <= inimigosvida[r_idx];
                if (w_pontua && w_muda) begin
                    r_placar  <= w_placar_prox;
                    r_ponto   <= 1'b1;
                    r_estouro <= w_estouro;
                end
            end
        end
    end

    assign placar_bcd   = r_placar;
    assign recorde_bcd  = r_recorde;
    assign ponto        = r_ponto;
    assign estouro      = r_estouro;
    assign novo_recorde = r_novo_recorde;
    assign jogando      = (r_estado == S_PLAYING);

endmodule
`default_nettype wire

// File: tb/tb_placar_parametrizado.sv
`default_nettype none
// ============================================================================
// Module   : tb_placar_parametrizado
// Purpose  : Scoreboard bench: two scoreboards (wrap, +1 / saturate, +7) on
//            shared stimulus, expected score updates queued per kill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_placar_parametrizado;

    typedef struct packed {
        logic [11:0] placar;
        logic        estouro;
    } esperado_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vec;
    logic        perdeu;
    logic        reiniciar;

    logic [11:0] a_placar, a_recorde, b_placar, b_recorde;
    logic        a_ponto, a_estouro, a_novo, a_jogando;
    logic        b_ponto, b_estouro, b_novo, b_jogando;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cnt_a    = 0;
    int          cnt_b    = 0;

    esperado_t   q_a[$];
    esperado_t   q_b[$];
    esperado_t   ea, eb;

    int          sa, sb, ra, rb;
    bit          playing;

    always #5 clk = ~clk;

    placar_parametrizado #(
        .N_INIMIGOS(8), .N_DIGITOS(3), .PONTOS_POR_ABATE(1), .SATURAR(1'b0)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst), .inimigosvida(vec),
        .perdeuJogo(perdeu), .reiniciarJogo(reiniciar),
        .placar_bcd(a_placar), .recorde_bcd(a_recorde),
        .ponto(a_ponto), .estouro(a_estouro),
        .novo_recorde(a_novo), .jogando(a_jogando)
    );

    placar_parametrizado #(
        .N_INIMIGOS(8), .N_DIGITOS(3), .PONTOS_POR_ABATE(7), .SATURAR(1'b1)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst), .inimigosvida(vec),
        .perdeuJogo(perdeu), .reiniciarJogo(reiniciar),
        .placar_bcd(b_placar), .recorde_bcd(b_recorde),
        .ponto(b_ponto), .estouro(b_estouro),
        .novo_recorde(b_novo), .jogando(b_jogando)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: one call per expected kill.
    task automatic push_kill();
        esperado_t e;
        int        nb;
        sa = sa + 1;
        e.estouro = 1'b0;
        if (sa == 1000) begin
            sa        = 0;
            e.estouro = 1'b1;
        end
        e.placar = to_bcd(sa);
        q_a.push_back(e);
        if (sa > ra) ra = sa;
        if (sb < 999) begin
            nb        = sb + 7;
            e.estouro = (nb >= 999);
            if (nb > 999) nb = 999;
            sb       = nb;
            e.placar = to_bcd(sb);
            q_b.push_back(e);
            if (sb > rb) rb = sb;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Clear the masked bits, let the scan see them, then revive them.
    task automatic kill_mask(input logic [7:0] m);
        int k;
        k   = $countones(vec & m);
        vec = vec & ~m;
        if (playing) begin
            for (int i = 0; i < k; i++) push_kill();
        end
        wait_cycles(10);
        vec = vec | m;
        wait_cycles(9);
    endtask

    task automatic pulse_restart();
        reiniciar = 1'b1;
        sa = 0; sb = 0; playing = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ponto) begin
                cnt_a++;
                check("a_ponto_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    ea = q_a.pop_front();
                    check("a_placar", 32'(a_placar), 32'(ea.placar));
                    check("a_estouro", 32'(a_estouro), 32'(ea.estouro));
                end
            end else begin
                check("a_estouro_idle", 32'(a_estouro), 32'd0);
            end
            if (b_ponto) begin
                cnt_b++;
                check("b_ponto_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    eb = q_b.pop_front();
                    check("b_placar", 32'(b_placar), 32'(eb.placar));
                    check("b_estouro", 32'(b_estouro), 32'(eb.estouro));
                end
            end else begin
                check("b_estouro_idle", 32'(b_estouro), 32'd0);
            end
        end
    end

    initial begin
        int  c0a, c0b;
        bit  seen;
        rst = 1'b1; vec = 8'hFF; perdeu = 1'b0; reiniciar = 1'b0;
        sa = 0; sb = 0; ra = 0; rb = 0; playing = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_placar",  32'(a_placar),  32'd0);
        check("rst_recorde", 32'(a_recorde), 32'd0);
        check("rst_ponto",   32'(a_ponto),   32'd0);
        check("rst_novo",    32'(a_novo),    32'd0);
        check("rst_jogando", 32'(a_jogando), 32'd1);
        check("rst_b_placar", 32'(b_placar), 32'd0);

        // single kill: one point, high score follows a cycle later
        c0a = cnt_a;
        vec = 8'hDF;
        push_kill();
        seen = 1'b0;
        for (int c = 0; c < 9 && !seen; c++) begin
            @(negedge clk);
            if (a_ponto) seen = 1'b1;
        end
        check("t1_ponto_seen", 32'(seen), 32'd1);
        check("t1_recorde_lag", 32'(a_recorde), 32'h000);
        @(negedge clk);
        check("t1_recorde", 32'(a_recorde), 32'h001);
        check("t1_novo",    32'(a_novo),    32'd1);
        wait_cycles(9);
        check("t1_one_ponto", 32'(cnt_a - c0a), 32'd1);
        vec = 8'hFF;
        wait_cycles(10);
        check("t1_rise_no_ponto", 32'(cnt_a - c0a), 32'd1);

        // 1->0->1 on one bit scores once
        c0a = cnt_a;
        kill_mask(8'h04);
        check("t2_one_ponto", 32'(cnt_a - c0a), 32'd1);

        // reach 12, lose, kills ignored, restart keeps high score
        kill_mask(8'hFF);
        kill_mask(8'h03);
        check("t4_placar_012", 32'(a_placar), 32'h012);
        check("t6_b_placar",   32'(b_placar), 32'(to_bcd(sb)));
        perdeu = 1'b1;
        playing = 1'b0;
        @(negedge clk);
        perdeu = 1'b0;
        @(negedge clk);
        check("t4_jogando_0", 32'(a_jogando), 32'd0);
        check("t4_b_jogando_0", 32'(b_jogando), 32'd0);
        c0a = cnt_a;
        kill_mask(8'h07);
        check("t4_frozen", 32'(a_placar), 32'h012);
        check("t4_no_ponto", 32'(cnt_a - c0a), 32'd0);
        pulse_restart();
        @(negedge clk);
        check("t4_restart_placar", 32'(a_placar),  32'h000);
        check("t4_restart_novo",   32'(a_novo),    32'd0);
        check("t4_restart_rec",    32'(a_recorde), 32'h012);
        check("t4_restart_b_rec",  32'(b_recorde), 32'(to_bcd(rb)));
        check("t4_restart_jog",    32'(a_jogando), 32'd1);

        // both strobes land on the cycle the scan reaches a cleared bit
        c0a = cnt_a; c0b = cnt_b;
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        vec = 8'hF7;
        wait_cycles(3);
        perdeu = 1'b1; reiniciar = 1'b1;
        @(negedge clk);
        perdeu = 1'b0; reiniciar = 1'b0;
        @(negedge clk);
        check("t5_jogando", 32'(a_jogando), 32'd1);
        wait_cycles(12);
        check("t5_no_ponto_a", 32'(cnt_a - c0a), 32'd0);
        check("t5_no_ponto_b", 32'(cnt_b - c0b), 32'd0);
        check("t5_placar", 32'(a_placar), 32'h000);
        vec = 8'hFF;
        wait_cycles(10);

        // reset in the middle of a game
        kill_mask(8'h0F);
        check("t5_pre_rst", 32'(a_placar), 32'h004);
        vec = 8'h7F;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_placar",  32'(a_placar),  32'd0);
        check("t5_rst_recorde", 32'(a_recorde), 32'd0);
        check("t5_rst_novo",    32'(a_novo),    32'd0);
        check("t5_rst_ponto",   32'(a_ponto),   32'd0);
        check("t5_rst_b_rec",   32'(b_recorde), 32'd0);
        sa = 0; sb = 0; ra = 0; rb = 0; playing = 1'b1;
        q_a.delete(); q_b.delete();
        c0a = cnt_a;
        rst = 1'b0;
        wait_cycles(10);
        check("t5_no_pending", 32'(cnt_a - c0a), 32'd0);
        vec = 8'hFF;
        wait_cycles(10);

        // run to all-nines, then wrap (A) / hold (B)
        for (int i = 0; i < 124; i++) kill_mask(8'hFF);
        kill_mask(8'h7F);
        check("t3_a_999",     32'(a_placar),  32'h999);
        check("t3_a_rec_999", 32'(a_recorde), 32'h999);
        check("t3_b_999",     32'(b_placar),  32'h999);
        c0b = cnt_b;
        kill_mask(8'h01);
        check("t3_a_wrap",     32'(a_placar),  32'h000);
        check("t3_a_rec_keep", 32'(a_recorde), 32'h999);
        check("t3_b_hold",     32'(b_placar),  32'h999);
        check("t3_b_no_ponto", 32'(cnt_b - c0b), 32'd0);
        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_b_drained", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
